// File: rtl/dogx_sample_serializer.sv
// rtl/dogx_sample_serializer.sv - DOGX sample framer and two-lane serializer with frame strobe
// Define DOGX_SER_PARITY_EN to carry even parity in word[0]; otherwise word[0] is 0.
module dogx_sample_serializer (
  input  logic        CLK_24M,
  input  logic        reset,
  input  logic        tx_enable,
  input  logic        sample_valid,
  input  logic [10:0] sample_data,
  input  logic        sample_alpha,
  input  logic        overflow_clr,
  output logic        sd1,
  output logic        sd0,
  output logic        fs,
  output logic        overflow
);
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_k;
  logic [2:0]  r_seq;
  logic [15:0] r_word;
  logic        r_hold_valid;
  logic [10:0] r_hold_data;
  logic        r_hold_alpha;
  logic        r_overflow;
  logic        r_sd1;
  logic        r_sd0;
  logic        r_fs;

  logic        w_accept;
  logic        w_last;
  logic        w_load;
  logic [10:0] w_load_data;
  logic        w_load_alpha;
  logic        w_parity;
  logic        w_hold_wr;
  logic        w_hold_clr;
  logic        w_ovf_set;

  assign w_accept = sample_valid & tx_enable;
  assign w_last   = (r_k == 3'd7);

  always_ff @(posedge CLK_24M or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // At the last bit the hold slot has priority over a fresh strobe; a disabled
  // transmitter drops whatever is held and stops after the current frame.
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_load_data  = sample_data;
    w_load_alpha = sample_alpha;
    w_hold_wr    = 1'b0;
    w_hold_clr   = 1'b0;
    w_ovf_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!w_last) begin
          w_hold_wr = w_accept;
          w_ovf_set = w_accept & r_hold_valid;
        end else if (!tx_enable) begin
          w_hold_clr  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_hold_valid) begin
          w_load       = 1'b1;
          w_load_data  = r_hold_data;
          w_load_alpha = r_hold_alpha;
          w_hold_wr    = w_accept;
          w_hold_clr   = ~w_accept;
        end else if (w_accept) begin
          w_load = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef DOGX_SER_PARITY_EN
  assign w_parity = ^{w_load_data, w_load_alpha, r_seq};
`else
  assign w_parity = 1'b0;
`endif

  always_ff @(posedge CLK_24M or negedge reset) begin
    if (!reset) begin
      r_k          <= 3'd0;
      r_seq        <= 3'd0;
      r_word       <= 16'd0;
      r_hold_valid <= 1'b0;
      r_hold_data  <= 11'd0;
      r_hold_alpha <= 1'b0;
      r_overflow   <= 1'b0;
      r_sd1        <= 1'b0;
      r_sd0        <= 1'b0;
      r_fs         <= 1'b0;
    end else begin
      if (w_load) begin
        r_word <= {w_load_data, w_load_alpha, r_seq, w_parity};
        r_seq  <= r_seq + 3'd1;
        r_k    <= 3'd0;
      end else if (r_state == ST_SHIFT) begin
        r_k <= r_k + 3'd1;
      end
      if (w_hold_wr) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= sample_data;
        r_hold_alpha <= sample_alpha;
      end else if (w_hold_clr) begin
        r_hold_valid <= 1'b0;
      end
      if (w_ovf_set)         r_overflow <= 1'b1;
      else if (overflow_clr) r_overflow <= 1'b0;
      // Output stage trails the frame position by one cycle.
      r_sd1 <= (r_state == ST_SHIFT) & r_word[4'd15 - {1'b0, r_k}];
      r_sd0 <= (r_state == ST_SHIFT) & r_word[{1'b0, 3'd7 - r_k}];
      r_fs  <= (r_state == ST_SHIFT) & (r_k == 3'd0);
    end
  end

  assign sd1      = r_sd1;
  assign sd0      = r_sd0;
  assign fs       = r_fs;
  assign overflow = r_overflow;
endmodule

// File: tb/tb_dogx_sample_serializer.sv
// tb/tb_dogx_sample_serializer.sv - self-checking bench for dogx_sample_serializer
module tb_dogx_sample_serializer;
  logic        CLK_24M = 1'b0;
  logic        reset = 1'b1;
  logic        tx_enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [10:0] sample_data = 11'd0;
  logic        sample_alpha = 1'b0;
  logic        overflow_clr = 1'b0;
  logic        sd1, sd0, fs, overflow;

  always #5 CLK_24M = ~CLK_24M;

  dogx_sample_serializer dut (
    .CLK_24M(CLK_24M), .reset(reset), .tx_enable(tx_enable),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_alpha(sample_alpha), .overflow_clr(overflow_clr),
    .sd1(sd1), .sd0(sd0), .fs(fs), .overflow(overflow)
  );

`ifdef DOGX_SER_PARITY_EN
  localparam logic [15:0] EXP_SINGLE = 16'hB4B1;
`else
  localparam logic [15:0] EXP_SINGLE = 16'hB4B0;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: transmitter busy flag, bit position, word, hold slot, seq, overflow.
  bit          m_busy;
  int          m_k;
  logic [15:0] m_word;
  int          m_seq;
  bit          m_hold_v;
  logic [10:0] m_hd;
  logic        m_ha;
  bit          m_ovf;
  logic        exp_sd1, exp_sd0, exp_fs, exp_ovf;
  logic [2:0]  cap[$];

  function automatic logic [15:0] make_word(input logic [10:0] d, input logic a, input int s);
    int v;
    v = int'(d) * 32 + int'(a) * 16 + (s % 8) * 2;
`ifdef DOGX_SER_PARITY_EN
    if ($countones(v) % 2 == 1) v = v + 1;
`endif
    return v[15:0];
  endfunction

  function automatic logic [15:0] cap_word(input int start);
    logic [7:0] w1, w0;
    for (int j = 0; j < 8; j++) begin
      w1 = {w1[6:0], (start + j < cap.size()) ? cap[start + j][1] : 1'bx};
      w0 = {w0[6:0], (start + j < cap.size()) ? cap[start + j][0] : 1'bx};
    end
    return {w1, w0};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_k = 0; m_word = 16'd0; m_seq = 0; m_hold_v = 0; m_ovf = 0;
  endtask

  task automatic model_load(input logic [10:0] d, input logic a);
    m_word = make_word(d, a, m_seq);
    m_seq  = (m_seq + 1) % 8;
    m_k    = 0;
    m_busy = 1;
  endtask

  // Applies current inputs to the model and the DUT for one clock, then records DUT outputs.
  task automatic tick();
    bit acc, ovf_set;
    exp_fs  = m_busy && (m_k == 0);
    exp_sd1 = m_busy && m_word[15 - m_k];
    exp_sd0 = m_busy && m_word[7 - m_k];
    acc = sample_valid && tx_enable;
    ovf_set = 0;
    if (!m_busy) begin
      if (acc) model_load(sample_data, sample_alpha);
    end else if (m_k != 7) begin
      m_k = m_k + 1;
      if (acc) begin
        if (m_hold_v) ovf_set = 1;
        m_hold_v = 1; m_hd = sample_data; m_ha = sample_alpha;
      end
    end else if (!tx_enable) begin
      m_hold_v = 0; m_busy = 0; m_k = 0;
    end else if (m_hold_v) begin
      model_load(m_hd, m_ha);
      if (acc) begin m_hd = sample_data; m_ha = sample_alpha; end
      else m_hold_v = 0;
    end else if (acc) begin
      model_load(sample_data, sample_alpha);
    end else begin
      m_busy = 0; m_k = 0;
    end
    if (ovf_set) m_ovf = 1;
    else if (overflow_clr) m_ovf = 0;
    exp_ovf = m_ovf;
    @(posedge CLK_24M); #1;
    cap.push_back({fs, sd1, sd0});
  endtask

  task automatic do_reset();
    reset = 1'b0; sample_valid = 1'b0; overflow_clr = 1'b0; tx_enable = 1'b1;
    repeat (2) @(posedge CLK_24M);
    #1;
    model_reset();
    reset = 1'b1;
    cap.delete();
  endtask

  task automatic test_reset();
    tx_enable = 1'b1; sample_valid = 1'b1; sample_data = 11'h7FF; sample_alpha = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge CLK_24M);
    #1;
    tests_run++; if (sd1 !== 1'b0) begin tests_failed++; $display("FAIL reset_sd1 got=%b exp=0", sd1); end
    tests_run++; if (sd0 !== 1'b0) begin tests_failed++; $display("FAIL reset_sd0 got=%b exp=0", sd0); end
    tests_run++; if (fs !== 1'b0) begin tests_failed++; $display("FAIL reset_fs got=%b exp=0", fs); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    sample_valid = 1'b0;
    model_reset();
    reset = 1'b1;
    cap.delete();
    tick();
    tests_run++;
    if ({fs, sd1, sd0, overflow} !== 4'b0) begin
      tests_failed++; $display("FAIL reset_release_idle got=%b exp=0000", {fs, sd1, sd0, overflow});
    end
  endtask

  task automatic test_single();
    logic [7:0] fpat;
    do_reset();
    sample_valid = 1'b1; sample_data = 11'h5A5; sample_alpha = 1'b1;
    tick();
    sample_valid = 1'b0;
    tests_run++;
    if ({fs, sd1, sd0} !== 3'b0) begin
      tests_failed++; $display("FAIL single_latency got=%b exp=000", {fs, sd1, sd0});
    end
    repeat (9) tick();
    tests_run++;
    if (cap_word(1) !== EXP_SINGLE) begin
      tests_failed++; $display("FAIL single_word got=%h exp=%h", cap_word(1), EXP_SINGLE);
    end
    for (int j = 0; j < 8; j++) fpat = {fpat[6:0], cap[1 + j][2]};
    tests_run++;
    if (fpat !== 8'h80) begin tests_failed++; $display("FAIL single_fs got=%b exp=10000000", fpat); end
    tests_run++;
    if (cap[9] !== 3'b0) begin tests_failed++; $display("FAIL single_idle got=%b exp=000", cap[9]); end
  endtask

  task automatic test_stream();
    logic [10:0] d[10];
    logic        a[10];
    int          bad_fs;
    do_reset();
    for (int f = 0; f < 10; f++) begin
      d[f] = 11'($urandom_range(0, 2047)); a[f] = 1'($urandom_range(0, 1));
      sample_valid = 1'b1; sample_data = d[f]; sample_alpha = a[f];
      tick();
      sample_valid = 1'b0;
      repeat (7) tick();
    end
    repeat (2) tick();
    bad_fs = 0;
    for (int t = 1; t <= 80; t++) if (cap[t][2] !== ((t - 1) % 8 == 0)) bad_fs++;
    tests_run++;
    if (bad_fs != 0) begin tests_failed++; $display("FAIL stream_fs_cadence got=%0d bad exp=0", bad_fs); end
    for (int f = 0; f < 10; f++) begin
      tests_run++;
      if (cap_word(1 + 8 * f) !== make_word(d[f], a[f], f % 8)) begin
        tests_failed++;
        $display("FAIL stream_word%0d got=%h exp=%h", f, cap_word(1 + 8 * f), make_word(d[f], a[f], f % 8));
      end
    end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL stream_overflow got=%b exp=0", overflow); end
    tests_run++;
    if (cap[81] !== 3'b0) begin tests_failed++; $display("FAIL stream_idle got=%b exp=000", cap[81]); end
  endtask

  task automatic test_overflow();
    logic [10:0] d[26];
    logic        a[26];
    logic        exp_o;
    do_reset();
    for (int t = 0; t < 26; t++) begin
      d[t] = 11'($urandom_range(0, 2047)); a[t] = 1'($urandom_range(0, 1));
      sample_data = d[t]; sample_alpha = a[t];
      sample_valid = (t == 0 || t == 2 || t == 4 || t == 11 || t == 12 || t == 13);
      overflow_clr = (t == 10 || t == 13 || t == 14);
      tick();
      if (t == 3 || t == 4 || t == 9 || t == 10 || t == 12 || t == 13 || t == 14) begin
        exp_o = (t == 4 || t == 9 || t == 12 || t == 13);
        tests_run++;
        if (overflow !== exp_o) begin
          tests_failed++; $display("FAIL ovf_flag_t%0d got=%b exp=%b", t, overflow, exp_o);
        end
      end
    end
    sample_valid = 1'b0; overflow_clr = 1'b0;
    tests_run++;
    if (cap_word(1) !== make_word(d[0], a[0], 0)) begin
      tests_failed++; $display("FAIL ovf_frame0 got=%h exp=%h", cap_word(1), make_word(d[0], a[0], 0));
    end
    tests_run++;
    if (cap_word(9) !== make_word(d[4], a[4], 1)) begin
      tests_failed++; $display("FAIL ovf_frame1_newest got=%h exp=%h", cap_word(9), make_word(d[4], a[4], 1));
    end
    tests_run++;
    if (cap_word(17) !== make_word(d[13], a[13], 2)) begin
      tests_failed++; $display("FAIL ovf_frame2_newest got=%h exp=%h", cap_word(17), make_word(d[13], a[13], 2));
    end
    tests_run++;
    if (cap[25] !== 3'b0) begin tests_failed++; $display("FAIL ovf_idle got=%b exp=000", cap[25]); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] d[3];
    logic        a[3];
    for (int i = 0; i < 3; i++) begin d[i] = 11'($urandom_range(0, 2047)); a[i] = 1'($urandom_range(0, 1)); end
    do_reset();
    for (int t = 0; t < 26; t++) begin
      sample_valid = (t == 0 || t == 3 || t == 8);
      sample_data  = (t == 0) ? d[0] : (t == 3) ? d[1] : d[2];
      sample_alpha = (t == 0) ? a[0] : (t == 3) ? a[1] : a[2];
      tick();
      if (t == 8) begin
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("FAIL b2b_no_overflow got=%b exp=0", overflow); end
      end
    end
    sample_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (cap_word(1 + 8 * i) !== make_word(d[i], a[i], i)) begin
        tests_failed++;
        $display("FAIL b2b_frame%0d got=%h exp=%h", i, cap_word(1 + 8 * i), make_word(d[i], a[i], i));
      end
    end
    tests_run++;
    if (cap[25] !== 3'b0 || overflow !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_end got=%b/%b exp=000/0", cap[25], overflow);
    end
  endtask

  task automatic test_disable();
    logic [10:0] d0, d1;
    logic        a0, a1;
    int          busy;
    d0 = 11'($urandom_range(0, 2047)); a0 = 1'($urandom_range(0, 1));
    d1 = 11'($urandom_range(0, 2047)); a1 = 1'($urandom_range(0, 1));
    do_reset();
    for (int t = 0; t < 33; t++) begin
      tx_enable    = !(t >= 4 && t < 14);
      sample_valid = (t == 0 || t == 2 || t == 5 || t == 6 || t == 12 || t == 23);
      sample_data  = (t == 23) ? d1 : (t == 0) ? d0 : 11'($urandom_range(0, 2047));
      sample_alpha = (t == 23) ? a1 : (t == 0) ? a0 : 1'b1;
      tick();
    end
    sample_valid = 1'b0; tx_enable = 1'b1;
    tests_run++;
    if (cap_word(1) !== make_word(d0, a0, 0)) begin
      tests_failed++; $display("FAIL dis_frame_completes got=%h exp=%h", cap_word(1), make_word(d0, a0, 0));
    end
    busy = 0;
    for (int t = 9; t <= 23; t++) if (cap[t] !== 3'b0) busy++;
    tests_run++;
    if (busy != 0) begin tests_failed++; $display("FAIL dis_quiet got=%0d active cycles exp=0", busy); end
    tests_run++;
    if (cap_word(24) !== make_word(d1, a1, 1)) begin
      tests_failed++; $display("FAIL dis_resume_seq got=%h exp=%h", cap_word(24), make_word(d1, a1, 1));
    end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL dis_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_reset_mid();
    int busy;
    do_reset();
    for (int t = 0; t < 6; t++) begin
      sample_valid = (t < 3); sample_data = 11'h7FF; sample_alpha = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    tests_run++;
    if ({sd1, overflow} !== 2'b11) begin
      tests_failed++; $display("FAIL rmid_pre got=%b exp=11", {sd1, overflow});
    end
    #1 reset = 1'b0;
    #1;
    tests_run++;
    if ({fs, sd1, sd0, overflow} !== 4'b0) begin
      tests_failed++; $display("FAIL rmid_async_clear got=%b exp=0000", {fs, sd1, sd0, overflow});
    end
    repeat (2) @(posedge CLK_24M);
    #1;
    model_reset(); reset = 1'b1; cap.delete();
    for (int t = 0; t < 18; t++) begin
      sample_valid = (t == 8); sample_data = 11'h5A5; sample_alpha = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    busy = 0;
    for (int t = 0; t <= 8; t++) if (cap[t] !== 3'b0) busy++;
    tests_run++;
    if (busy != 0) begin tests_failed++; $display("FAIL rmid_hold_dropped got=%0d active exp=0", busy); end
    tests_run++;
    if (cap_word(9) !== EXP_SINGLE) begin
      tests_failed++; $display("FAIL rmid_seq0 got=%h exp=%h", cap_word(9), EXP_SINGLE);
    end
  endtask

  task automatic test_random();
    int bad, ovf_cycles;
    do_reset();
    bad = 0; ovf_cycles = 0;
    for (int c = 0; c < 1500; c++) begin
      tx_enable    = ($urandom_range(0, 19) != 0);
      sample_valid = ($urandom_range(0, 4) == 0);
      sample_data  = 11'($urandom_range(0, 2047));
      sample_alpha = 1'($urandom_range(0, 1));
      overflow_clr = ($urandom_range(0, 9) == 0);
      tick();
      if (exp_ovf) ovf_cycles++;
      tests_run++;
      if ({sd1, sd0, fs, overflow} !== {exp_sd1, exp_sd0, exp_fs, exp_ovf}) begin
        tests_failed++; bad++;
        if (bad < 10)
          $display("FAIL random_c%0d got=%b exp=%b", c, {sd1, sd0, fs, overflow},
                   {exp_sd1, exp_sd0, exp_fs, exp_ovf});
      end
    end
    sample_valid = 1'b0; overflow_clr = 1'b0;
    tests_run++;
    if (ovf_cycles == 0) begin tests_failed++; $display("FAIL random_ovf_exercised got=0 exp>0"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_overflow();
    test_back_to_back();
    test_disable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/dogx_sample_serializer.md
# dogx_sample_serializer

Output-side transmitter for the DOGX converter. It accepts the 11-bit converter sample and the alpha flag once per 3 MHz sample slot, packs them with a sequence count and parity into a 16-bit frame, and shifts the frame off-chip on two serial lanes with a frame strobe, all at 24 MHz. It sits directly after the converter output register and drives the chip's serial sample port.

## Interface
Parameters:
- none

Ports:
- CLK_24M  input  1  system clock, 24 MHz; every register updates on its rising edge
- reset  input  1  asynchronous, active-low; all state is cleared while low
- tx_enable  input  1  transmitter enable; when low, new samples are ignored
- sample_valid  input  1  one-cycle strobe, nominally 1 in 8 cycles; samples sample_data/sample_alpha
- sample_data  input  11  converter sample, two's complement
- sample_alpha  input  1  alpha (HDR select) flag of the sample
- overflow_clr  input  1  synchronous clear of overflow
- sd1  output  1  serial lane 1, carries word[15:8] MSB first
- sd0  output  1  serial lane 0, carries word[7:0] MSB first
- fs  output  1  frame strobe, high during bit 0 of each frame
- overflow  output  1  sticky flag, set when a held sample is overwritten

## Operation
- Frame word: word[15:5]=sample_data, word[4]=sample_alpha, word[3:1]=seq, word[0]=parity. Parity is the XOR of word[15:1], so the XOR of all 16 bits is 0.
- seq is a 3-bit counter. It is captured into each word when the frame loads, increments after each load, and wraps 7->0.
- A 3-bit bit counter k runs 0..7 per frame. In bit k, sd1=word[15-k], sd0=word[7-k], and fs=(k==0).
- States:
  - IDLE: sd0, sd1 and fs are 0. On sample_valid with tx_enable=1, load the frame and go to SHIFT with k=0.
  - SHIFT: k increments each cycle. At k==7, a pending sample loads back-to-back (next cycle is k=0 with fs=1). Otherwise return to IDLE.
- One-deep hold register (hold_valid, hold_data, hold_alpha). While in SHIFT, an accepted sample goes to hold.
- Load source at k==7, in priority order:
  - hold_valid: hold is loaded. If sample_valid arrives in the same cycle, it fills hold.
  - sample_valid only: the new sample loads directly.
- Overflow:
  - A sample_valid arriving while hold_valid=1 and k!=7 overwrites hold (newest wins) and sets overflow.
  - overflow_clr clears overflow. If a set and a clear occur in the same cycle, the set wins.
- tx_enable=0:
  - sample_valid is ignored and never counts as overflow.
  - The frame in flight completes.
  - hold is cleared at frame end, and the FSM goes to IDLE.
- Reset mid-frame: outputs are forced to 0 immediately and the frame is abandoned. seq, hold and overflow clear.

## Timing
- All outputs are registered. Reset values: sd0=0, sd1=0, fs=0, overflow=0. Internal reset values: seq=0, k=0, hold_valid=0, state IDLE.
- Latency: with sample_valid high at posedge N (in IDLE), fs, sd1 and sd0 carry bit 0 after posedge N+1 and stay valid until posedge N+2.
- One frame is exactly 8 cycles. With sample_valid every 8th cycle, output is continuous and fs pulses every 8 cycles.
- overflow rises on the edge that registers the overwrite. It falls on the edge after overflow_clr is sampled high.

## Configuration
- DOGX_SER_PARITY_EN:
  - Defined: word[0] is the parity bit described above.
  - Undefined: word[0] is constant 0 and no parity logic is built.
  - Frame length and all other fields are identical in both builds.

## Test plan
- Reset, then tx_enable=1 with one sample_valid: sample_data=11'h5A5, sample_alpha=1. Expect word 0xB4B1. Over 8 cycles sd1 = 1,0,1,1,0,1,0,0 and sd0 = 1,0,1,1,0,0,0,1. fs is high only in the first cycle, which is 1 cycle after the strobe. Then IDLE with outputs at 0.
- Ten samples at exact 8-cycle spacing: continuous frames, seq 0..7,0,1 with wrap, no gaps, overflow stays 0.
- Two strobes 2 cycles apart mid-frame, then a third 2 cycles later (hold full): overflow=1. The second frame carries the third sample. overflow_clr drops the flag, except when overflow_clr coincides with a new overwrite, in which case the flag stays 1.
- Pending hold plus sample_valid at k==7: hold transmits next, the new sample moves into hold, and no overflow occurs.
- tx_enable dropped at k=3 with hold full: the current frame finishes, hold is discarded, IDLE follows. Strobes while disabled produce nothing.
- Reset asserted at k=4: outputs are 0 immediately. After release, the next frame carries seq=0. Build without DOGX_SER_PARITY_EN: 0x5A5/alpha=1 gives 0xB4B0.
